// File: rtl/adc_frame_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// adc_frame_ctrl_pkg
//  Shared definitions for the ADC frame controller and the FFT input block:
//  controller state encoding and default frame geometry.
//  Ports: none (package).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package adc_frame_ctrl_pkg;

   localparam int DW_DEF        = 8;
   localparam int FRAME_LEN_DEF = 1024;
   localparam int LEN_W_DEF     = 10;
   localparam int CNT_W_DEF     = 16;

   // Encodings are fixed: the FFT input block decodes these values.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TRIG = 2'd1,
      CAPTURE   = 2'd2
   } state_t;

endpackage

// File: rtl/adc_trig_detect.sv
// ----------------------------------------------------------------------------
// adc_trig_detect
//  Level-crossing trigger detector. Remembers the previous valid sample while
//  tracking is enabled and compares it with the current one against an
//  unsigned threshold. hit is combinational and qualified by s_valid.
//  Ports:
//   sysclk_250m  clock
//   sys_rst      asynchronous reset, active-low
//   s_data       current sample
//   s_valid      current sample valid
//   track        1 while the controller is waiting for a trigger
//   trig_en      0 = every valid sample hits, 1 = level crossing
//   trig_rising  1 = rising crossing, 0 = falling crossing
//   trig_level   threshold (unsigned)
//   hit          trigger condition for the current sample
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module adc_trig_detect #(
   parameter int DW = 8
) (
   input  logic          sysclk_250m,
   input  logic          sys_rst,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   input  logic          track,
   input  logic          trig_en,
   input  logic          trig_rising,
   input  logic [DW-1:0] trig_level,
   output logic          hit
);

   logic [DW-1:0] prev_p1;
   logic          prev_vld_p1;
   logic          rise;
   logic          fall;

   // Holding prev_vld low outside tracking guarantees it is clear on every
   // entry to the wait state, so the first sample seen can never trigger.
   always_ff @(posedge sysclk_250m or negedge sys_rst) begin
      if (!sys_rst) begin
         prev_p1     <= '0;
         prev_vld_p1 <= 1'b0;
      end else if (!track) begin
         prev_vld_p1 <= 1'b0;
      end else if (s_valid) begin
         prev_p1     <= s_data;
         prev_vld_p1 <= 1'b1;
      end
   end

   always_comb begin
      rise = (prev_p1 < trig_level) && (s_data >= trig_level);
      fall = (prev_p1 > trig_level) && (s_data <= trig_level);
      hit  = s_valid && (!trig_en || (prev_vld_p1 && (trig_rising ? rise : fall)));
   end

endmodule

// File: rtl/adc_frame_ctrl.sv
// ----------------------------------------------------------------------------
// adc_frame_ctrl
//  Cuts the capture-FIFO sample stream into fixed-length frames for the FFT.
//  Arm/stop control, free-run or level trigger, single or continuous capture,
//  SOP/EOP marking, abort on sink stall, frame and overflow statistics.
//  All outputs are registered: one cycle from accepted sample to m_*.
//  Ports:
//   sysclk_250m  sole clock
//   sys_rst      asynchronous reset, active-low
//   s_data/s_valid                  sample stream from capture FIFO
//   arm/stop                        1-cycle control pulses
//   continuous                      re-arm after each EOP
//   trig_en/trig_rising/trig_level  trigger setup
//   m_data/m_valid/m_sop/m_eop      frame stream to FFT
//   m_abort                         current frame discarded
//   m_ready                         FFT can accept a sample
//   busy                            controller not idle
//   done                            EOP of a single-shot frame
//   frame_cnt                       completed frames (wraps)
//   ovf_cnt                         aborted frames (saturates)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module adc_frame_ctrl
   import adc_frame_ctrl_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int LEN_W     = LEN_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             sysclk_250m,
   input  logic             sys_rst,
   input  logic [DW-1:0]    s_data,
   input  logic             s_valid,
   input  logic             arm,
   input  logic             stop,
   input  logic             continuous,
   input  logic             trig_en,
   input  logic             trig_rising,
   input  logic [DW-1:0]    trig_level,
   output logic [DW-1:0]    m_data,
   output logic             m_valid,
   output logic             m_sop,
   output logic             m_eop,
   output logic             m_abort,
   input  logic             m_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] ovf_cnt
);

   localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(FRAME_LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] idx;
   logic [LEN_W-1:0] idx_nxt;
   logic             cont_q;
   logic             cont_nxt;
   logic             trig_hit;

   logic             accept;
   logic             sop_nxt;
   logic             eop_nxt;
   logic             abort_nxt;
   logic             done_nxt;
   logic             frame_inc;
   logic             ovf_inc;

   logic [DW-1:0]    data_p1;
   logic             vld_p1;
   logic             sop_p1;
   logic             eop_p1;
   logic             abort_p1;
   logic             done_p1;
   logic [CNT_W-1:0] frame_cnt_p1;
   logic [CNT_W-1:0] ovf_cnt_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   adc_trig_detect #(
      .DW (DW)
   ) u_trig (
      .sysclk_250m (sysclk_250m),
      .sys_rst     (sys_rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .track       (state == WAIT_TRIG),
      .trig_en     (trig_en),
      .trig_rising (trig_rising),
      .trig_level  (trig_level),
      .hit         (trig_hit)
   );

   always_ff @(posedge sysclk_250m or negedge sys_rst) begin
      if (!sys_rst) begin
         state  <= IDLE;
         idx    <= '0;
         cont_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         cont_q <= cont_nxt;
      end
   end

   // continuous is captured with the SOP so a mid-frame change only affects
   // what happens after the following trigger evaluation.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cont_nxt  = cont_q;
      accept    = 1'b0;
      sop_nxt   = 1'b0;
      eop_nxt   = 1'b0;
      abort_nxt = 1'b0;
      done_nxt  = 1'b0;
      frame_inc = 1'b0;
      ovf_inc   = 1'b0;
      if (stop) begin
         // stop outranks arm, trigger and EOP; a frame in flight is abandoned
         // without counting as an overflow.
         state_nxt = IDLE;
         idx_nxt   = '0;
         if (state == CAPTURE) abort_nxt = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (arm) state_nxt = WAIT_TRIG;
            end
            WAIT_TRIG: begin
               // A trigger sample the sink cannot take is simply skipped.
               if (trig_hit && m_ready) begin
                  accept    = 1'b1;
                  sop_nxt   = 1'b1;
                  idx_nxt   = LEN_W'(1);
                  cont_nxt  = continuous;
                  state_nxt = CAPTURE;
               end
            end
            CAPTURE: begin
               if (s_valid) begin
                  if (!m_ready) begin
                     abort_nxt = 1'b1;
                     ovf_inc   = 1'b1;
                     idx_nxt   = '0;
                     state_nxt = cont_q ? WAIT_TRIG : IDLE;
                  end else begin
                     accept = 1'b1;
                     if (idx == LAST_IDX) begin
                        eop_nxt   = 1'b1;
                        frame_inc = 1'b1;
                        done_nxt  = !cont_q;
                        idx_nxt   = '0;
                        state_nxt = cont_q ? WAIT_TRIG : IDLE;
                     end else begin
                        idx_nxt = idx + LEN_W'(1);
                     end
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   // ---- output stage p1: registered copy of the accepted sample ----
   always_ff @(posedge sysclk_250m or negedge sys_rst) begin
      if (!sys_rst) begin
         data_p1      <= '0;
         vld_p1       <= 1'b0;
         sop_p1       <= 1'b0;
         eop_p1       <= 1'b0;
         abort_p1     <= 1'b0;
         done_p1      <= 1'b0;
         frame_cnt_p1 <= '0;
         ovf_cnt_p1   <= '0;
      end else begin
         if (accept) data_p1 <= s_data;
         vld_p1   <= accept;
         sop_p1   <= sop_nxt;
         eop_p1   <= eop_nxt;
         abort_p1 <= abort_nxt;
         done_p1  <= done_nxt;
         if (frame_inc) frame_cnt_p1 <= frame_cnt_p1 + CNT_W'(1);
         if (ovf_inc)   ovf_cnt_p1   <= sat_inc(ovf_cnt_p1);
      end
   end

   assign m_data    = data_p1;
   assign m_valid   = vld_p1;
   assign m_sop     = sop_p1;
   assign m_eop     = eop_p1;
   assign m_abort   = abort_p1;
   assign done      = done_p1;
   assign frame_cnt = frame_cnt_p1;
   assign ovf_cnt   = ovf_cnt_p1;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adc_frame_ctrl
//  Directed bench for adc_frame_ctrl with FRAME_LEN = 8. Inputs change 1 ns
//  after the rising edge; outputs are sampled at that same point, so each
//  step() shows the registered response to the sample driven before the edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_frame_ctrl;

   localparam int DW        = 8;
   localparam int FRAME_LEN = 8;
   localparam int LEN_W     = 3;
   localparam int CNT_W     = 16;

   logic             sysclk_250m = 1'b0;
   logic             sys_rst     = 1'b0;
   logic [DW-1:0]    s_data      = '0;
   logic             s_valid     = 1'b0;
   logic             arm         = 1'b0;
   logic             stop        = 1'b0;
   logic             continuous  = 1'b0;
   logic             trig_en     = 1'b0;
   logic             trig_rising = 1'b1;
   logic [DW-1:0]    trig_level  = '0;
   logic             m_ready     = 1'b1;
   logic [DW-1:0]    m_data;
   logic             m_valid;
   logic             m_sop;
   logic             m_eop;
   logic             m_abort;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] ovf_cnt;

   int checks   = 0;
   int failures = 0;

   always #2 sysclk_250m = ~sysclk_250m;

   adc_frame_ctrl #(
      .DW        (DW),
      .FRAME_LEN (FRAME_LEN),
      .LEN_W     (LEN_W),
      .CNT_W     (CNT_W)
   ) dut (
      .sysclk_250m (sysclk_250m),
      .sys_rst     (sys_rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .arm         (arm),
      .stop        (stop),
      .continuous  (continuous),
      .trig_en     (trig_en),
      .trig_rising (trig_rising),
      .trig_level  (trig_level),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_sop       (m_sop),
      .m_eop       (m_eop),
      .m_abort     (m_abort),
      .m_ready     (m_ready),
      .busy        (busy),
      .done        (done),
      .frame_cnt   (frame_cnt),
      .ovf_cnt     (ovf_cnt)
   );

   task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
      s_valid = v;
      s_data  = d;
      m_ready = r;
      @(posedge sysclk_250m);
      #1;
      s_valid = 1'b0;
      arm     = 1'b0;
      stop    = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      repeat (2) @(posedge sysclk_250m);
      #1;
      checks++; if ({m_valid, m_sop, m_eop, m_abort, done, busy} !== 6'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=000000", {m_valid, m_sop, m_eop, m_abort, done, busy}); end
      checks++; if (m_data !== 8'h00) begin
         failures++; $display("FAIL reset_data got=%h exp=00", m_data); end
      checks++; if ({frame_cnt, ovf_cnt} !== 32'h0) begin
         failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", frame_cnt, ovf_cnt); end
      sys_rst = 1'b1;
      step(1'b1, 8'h11, 1'b1);
      checks++; if ({m_valid, busy} !== 2'b00) begin
         failures++; $display("FAIL reset_idle got=%b exp=00", {m_valid, busy}); end
   endtask

   // Free-run single shot: samples 0..19, only 0..7 form the frame.
   task automatic test_freerun_single();
      continuous = 1'b0; trig_en = 1'b0;
      do_arm();
      checks++; if (busy !== 1'b1) begin
         failures++; $display("FAIL t1_busy_armed got=%b exp=1", busy); end
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'(i), 1'b1);
         if (i < 8) begin
            checks++; if ({m_valid, m_data, m_sop, m_eop, done} !== {1'b1, 8'(i), i == 0, i == 7, i == 7}) begin
               failures++; $display("FAIL t1_sample[%0d] got v=%b d=%h s=%b e=%b dn=%b exp d=%h", i, m_valid, m_data, m_sop, m_eop, done, 8'(i)); end
         end else begin
            checks++; if (m_valid !== 1'b0) begin
               failures++; $display("FAIL t1_after[%0d] got v=%b exp=0", i, m_valid); end
         end
         if (i == 7) begin
            checks++; if (frame_cnt !== 16'd1) begin
               failures++; $display("FAIL t1_frame_cnt got=%0d exp=1", frame_cnt); end
            checks++; if (busy !== 1'b0) begin
               failures++; $display("FAIL t1_busy_done got=%b exp=0", busy); end
         end
      end
   endtask

   // Rising trigger at 0x80; leading 0x90 is already above level but is the
   // first sample seen, so it must not trigger.
   task automatic test_rising_trigger();
      logic [DW-1:0] v;
      continuous = 1'b0; trig_en = 1'b1; trig_rising = 1'b1; trig_level = 8'h80;
      do_arm();
      for (int k = 0; k < 12; k++) begin
         v = (k == 0) ? 8'h90 : 8'(8'h68 + 8 * k);
         step(1'b1, v, 1'b1);
         if (k < 3 || k > 10) begin
            checks++; if (m_valid !== 1'b0) begin
               failures++; $display("FAIL t2_no_out[%0d] got v=%b exp=0", k, m_valid); end
         end else begin
            checks++; if ({m_valid, m_data, m_sop, m_eop} !== {1'b1, v, k == 3, k == 10}) begin
               failures++; $display("FAIL t2_frame[%0d] got v=%b d=%h s=%b e=%b exp d=%h", k, m_valid, m_data, m_sop, m_eop, v); end
         end
      end
      checks++; if (frame_cnt !== 16'd2) begin
         failures++; $display("FAIL t2_frame_cnt got=%0d exp=2", frame_cnt); end
   endtask

   task automatic test_back_to_back();
      continuous = 1'b1; trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b1);
         checks++; if ({m_valid, m_data, m_sop, m_eop, done} !== {1'b1, 8'(8'h40 + i), (i % 8) == 0, (i % 8) == 7, 1'b0}) begin
            failures++; $display("FAIL t3_sample[%0d] got v=%b d=%h s=%b e=%b dn=%b exp d=%h", i, m_valid, m_data, m_sop, m_eop, done, 8'(8'h40 + i)); end
      end
      checks++; if (frame_cnt !== 16'd5) begin
         failures++; $display("FAIL t3_frame_cnt got=%0d exp=5", frame_cnt); end
      stop = 1'b1;
      step(1'b0, '0, 1'b1);
      checks++; if ({m_abort, busy} !== 2'b00) begin
         failures++; $display("FAIL t3_stop_idle got abort=%b busy=%b exp 0 0", m_abort, busy); end
   endtask

   task automatic test_abort();
      continuous = 1'b1; trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b1);
      step(1'b1, 8'h24, 1'b0);
      checks++; if ({m_abort, m_valid, m_eop} !== 3'b100) begin
         failures++; $display("FAIL t4_abort got abort=%b v=%b e=%b exp 1 0 0", m_abort, m_valid, m_eop); end
      checks++; if (ovf_cnt !== 16'd1) begin
         failures++; $display("FAIL t4_ovf_cnt got=%0d exp=1", ovf_cnt); end
      step(1'b1, 8'h25, 1'b0);
      checks++; if ({m_abort, m_valid} !== 2'b00) begin
         failures++; $display("FAIL t4_skip got abort=%b v=%b exp 0 0", m_abort, m_valid); end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'(8'hA0 + i), 1'b1);
         checks++; if ({m_valid, m_data, m_sop, m_eop, m_abort} !== {1'b1, 8'(8'hA0 + i), i == 0, i == 7, 1'b0}) begin
            failures++; $display("FAIL t4_fresh[%0d] got v=%b d=%h s=%b e=%b a=%b exp d=%h", i, m_valid, m_data, m_sop, m_eop, m_abort, 8'(8'hA0 + i)); end
      end
      checks++; if ({frame_cnt, ovf_cnt} !== {16'd6, 16'd1}) begin
         failures++; $display("FAIL t4_cnts got=%0d/%0d exp=6/1", frame_cnt, ovf_cnt); end
      stop = 1'b1;
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_stop_arm();
      continuous = 1'b0; trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
      stop = 1'b1; arm = 1'b1;
      step(1'b1, 8'h33, 1'b1);
      checks++; if ({m_abort, m_valid, m_eop, busy} !== 4'b1000) begin
         failures++; $display("FAIL t5_stop got abort=%b v=%b e=%b busy=%b exp 1 0 0 0", m_abort, m_valid, m_eop, busy); end
      checks++; if ({frame_cnt, ovf_cnt} !== {16'd6, 16'd1}) begin
         failures++; $display("FAIL t5_cnts got=%0d/%0d exp=6/1", frame_cnt, ovf_cnt); end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b1);
         checks++; if ({m_valid, m_abort, busy} !== 3'b000) begin
            failures++; $display("FAIL t5_no_rearm[%0d] got v=%b a=%b busy=%b exp 0 0 0", i, m_valid, m_abort, busy); end
      end
   endtask

   task automatic test_async_reset();
      continuous = 1'b0; trig_en = 1'b0;
      do_arm();
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
      #0.5;
      sys_rst = 1'b0;
      #0.5;
      checks++; if ({m_valid, m_data, busy, frame_cnt, ovf_cnt} !== '0) begin
         failures++; $display("FAIL t6_async got v=%b d=%h busy=%b fc=%0d oc=%0d exp all 0", m_valid, m_data, busy, frame_cnt, ovf_cnt); end
      @(posedge sysclk_250m);
      #1;
      sys_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'(8'h60 + i), 1'b1);
         checks++; if ({m_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL t6_post[%0d] got v=%b busy=%b exp 0 0", i, m_valid, busy); end
      end
      do_arm();
      step(1'b1, 8'h77, 1'b1);
      checks++; if ({m_valid, m_sop, m_data} !== {1'b1, 1'b1, 8'h77}) begin
         failures++; $display("FAIL t6_rearm got v=%b s=%b d=%h exp 1 1 77", m_valid, m_sop, m_data); end
   endtask

   initial begin
      test_reset();
      test_freerun_single();
      test_rising_trigger();
      test_back_to_back();
      test_abort();
      test_stop_arm();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
